// File: rtl/lru_pkg.sv
// Shared tree-PLRU types and reference functions for the default configuration.
// Heap-ordered tree: root is bit 0, children of node n are 2n+1 and 2n+2.
package lru_pkg;

   localparam int unsigned LRU_WAYS   = 4;
   localparam int unsigned LRU_WIDTH  = LRU_WAYS - 1;
   localparam int unsigned LRU_WAY_W  = $clog2(LRU_WAYS);
   localparam int unsigned LRU_NODE_W = (LRU_WIDTH > 1) ? $clog2(LRU_WIDTH) : 1;

   typedef logic [LRU_WAY_W-1:0]  lru_way_t;
   typedef logic [LRU_WIDTH-1:0]  lru_bits_t;
   typedef logic [LRU_NODE_W-1:0] lru_node_t;

   // Walk from the root: bit=0 goes left, bit=1 goes right; path bits form the way index.
   function automatic lru_way_t plru_victim(lru_bits_t bits);
      lru_way_t  way  = '0;
      lru_node_t node = '0;
      logic      dir;
      for (int unsigned l = 0; l < LRU_WAY_W; l++) begin
         dir  = bits[node];
         way  = lru_way_t'({way, dir});
         node = lru_node_t'(32'(node) * 2 + 32'(dir) + 1);
      end
      return way;
   endfunction

   // Every node on the path to way is pointed away from it; off-path bits are kept.
   function automatic lru_bits_t plru_touch(lru_bits_t bits, lru_way_t way);
      lru_bits_t res  = bits;
      lru_way_t  w    = way;
      lru_node_t node = '0;
      logic      dir;
      for (int unsigned l = 0; l < LRU_WAY_W; l++) begin
         dir       = w[LRU_WAY_W-1];
         w         = w << 1;
         res[node] = ~dir;
         node      = lru_node_t'(32'(node) * 2 + 32'(dir) + 1);
      end
      return res;
   endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU victim select (or hit way pass-through) and updated-bit generation.
module plru_tree #(
   parameter int unsigned WAYS  = 4,
   parameter int unsigned WIDTH = WAYS - 1
) (
   input  logic [WIDTH-1:0]         i_bits,
   input  logic                     i_hit,
   input  logic [$clog2(WAYS)-1:0]  i_way,
   output logic [$clog2(WAYS)-1:0]  o_way,
   output logic [WIDTH-1:0]         o_bits
);

   localparam int unsigned WAY_W  = $clog2(WAYS);
   localparam int unsigned NODE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WAY_W-1:0]  w_victim;
   logic [WAY_W-1:0]  w_way;
   logic [WAY_W-1:0]  w_shift;
   logic [NODE_W-1:0] w_node;
   logic [WIDTH-1:0]  w_bits;
   logic              w_dir;

   always_comb begin
      w_victim = '0;
      w_node   = '0;
      w_dir    = 1'b0;
      for (int unsigned l = 0; l < WAY_W; l++) begin
         w_dir    = i_bits[w_node];
         w_victim = WAY_W'({w_victim, w_dir});
         w_node   = NODE_W'(32'(w_node) * 2 + 32'(w_dir) + 1);
      end

      w_way = i_hit ? i_way : w_victim;

      // Second walk follows the touched way MSB-first and flips each path node away from it.
      w_bits  = i_bits;
      w_shift = w_way;
      w_node  = '0;
      for (int unsigned l = 0; l < WAY_W; l++) begin
         w_dir          = w_shift[WAY_W-1];
         w_shift        = w_shift << 1;
         w_bits[w_node] = ~w_dir;
         w_node         = NODE_W'(32'(w_node) * 2 + 32'(w_dir) + 1);
      end
   end

   assign o_way  = w_way;
   assign o_bits = w_bits;

endmodule

// File: rtl/plru_update_ctrl.sv
// Two-stage PLRU update initiator: reads set bits on port 0, returns the touched way and
// writes the updated bits back on port 1 when the response is consumed.
module plru_update_ctrl
   import lru_pkg::*;
#(
   parameter int unsigned S_INDEX = 4,
   parameter int unsigned WAYS    = LRU_WAYS,
   parameter int unsigned WIDTH   = WAYS - 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [S_INDEX-1:0]       req_set,
   input  logic                     req_hit,
   input  logic [$clog2(WAYS)-1:0]  req_way,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [$clog2(WAYS)-1:0]  resp_way,
   output logic                     lru_csb0,
   output logic                     lru_web0,
   output logic [S_INDEX-1:0]       lru_addr0,
   input  logic [WIDTH-1:0]         lru_dout0,
   output logic                     lru_csb1,
   output logic                     lru_web1,
   output logic [S_INDEX-1:0]       lru_addr1,
   output logic [WIDTH-1:0]         lru_din1
);

   logic                     r_s1_valid;
   logic [S_INDEX-1:0]       r_s1_set;
   logic                     r_s1_hit;
   logic [$clog2(WAYS)-1:0]  r_s1_way;

   logic                     w_fire;
   logic                     w_accept;
   logic [$clog2(WAYS)-1:0]  w_touch_way;
   logic [WIDTH-1:0]         w_new_bits;

   // Reset suppresses both array commands so a dropped S1 never writes back.
   assign w_fire    = r_s1_valid && resp_ready && !rst;
   assign req_ready = !r_s1_valid || resp_ready;
   assign w_accept  = req_valid && req_ready && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
      end else if (req_ready) begin
         r_s1_valid <= req_valid;
      end
      if (w_accept) begin
         r_s1_set <= req_set;
         r_s1_hit <= req_hit;
         r_s1_way <= req_way;
      end
   end

   plru_tree #(
      .WAYS  (WAYS),
      .WIDTH (WIDTH)
   ) u_tree (
      .i_bits (lru_dout0),
      .i_hit  (r_s1_hit),
      .i_way  (r_s1_way),
      .o_way  (w_touch_way),
      .o_bits (w_new_bits)
   );

   assign resp_valid = r_s1_valid;
   assign resp_way   = w_touch_way;

   assign lru_csb0  = !w_accept;
   assign lru_web0  = 1'b1;
   assign lru_addr0 = req_set;

   assign lru_csb1  = !w_fire;
   assign lru_web1  = !w_fire;
   assign lru_addr1 = r_s1_set;
   assign lru_din1  = w_new_bits;

endmodule

// File: tb/tb_plru_update_ctrl.sv
// Directed bench for plru_update_ctrl with a behavioural lru_array (registered read,
// one-cycle write landing, pending-write forwarding, reset to zero).
module tb_plru_update_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_set;
   logic       req_hit;
   logic [1:0] req_way;
   logic       resp_valid;
   logic       resp_ready;
   logic [1:0] resp_way;
   logic       lru_csb0, lru_web0, lru_csb1, lru_web1;
   logic [3:0] lru_addr0, lru_addr1;
   logic [2:0] lru_dout0, lru_din1;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   plru_update_ctrl #(
      .S_INDEX (4),
      .WAYS    (4),
      .WIDTH   (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_set    (req_set),
      .req_hit    (req_hit),
      .req_way    (req_way),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_way   (resp_way),
      .lru_csb0   (lru_csb0),
      .lru_web0   (lru_web0),
      .lru_addr0  (lru_addr0),
      .lru_dout0  (lru_dout0),
      .lru_csb1   (lru_csb1),
      .lru_web1   (lru_web1),
      .lru_addr1  (lru_addr1),
      .lru_din1   (lru_din1)
   );

   // Behavioural array
   logic [2:0] mem [16];
   logic [3:0] rd_addr;
   logic       wr_pend;
   logic [3:0] wr_addr;
   logic [2:0] wr_data;
   int         wr_count = 0;
   int         wr7_count = 0;

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 16; k++) mem[k] <= '0;
         wr_pend <= 1'b0;
      end else begin
         if (wr_pend) mem[wr_addr] <= wr_data;
         wr_pend <= !lru_csb1 && !lru_web1;
         wr_addr <= lru_addr1;
         wr_data <= lru_din1;
      end
      if (!lru_csb0) rd_addr <= lru_addr0;
      if (!lru_csb1 && !lru_web1) begin
         wr_count <= wr_count + 1;
         if (lru_addr1 == 4'd7) wr7_count <= wr7_count + 1;
      end
   end

   assign lru_dout0 = (wr_pend && wr_addr == rd_addr) ? wr_data : mem[rd_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic [3:0] set;
      logic       hit;
      logic [1:0] way;
      logic [1:0] exp_way;
      logic [2:0] exp_din;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w_before;
      int w7_before;

      vecs[0] = '{4'd3, 1'b0, 2'd0, 2'd0, 3'b011};
      vecs[1] = '{4'd5, 1'b0, 2'd0, 2'd0, 3'b011};
      vecs[2] = '{4'd5, 1'b0, 2'd0, 2'd2, 3'b110};
      vecs[3] = '{4'd5, 1'b0, 2'd0, 2'd1, 3'b101};
      vecs[4] = '{4'd5, 1'b0, 2'd0, 2'd3, 3'b000};
      vecs[5] = '{4'd1, 1'b1, 2'd2, 2'd2, 3'b100};
      vecs[6] = '{4'd1, 1'b0, 2'd0, 2'd0, 3'b111};
      vecs[7] = '{4'd2, 1'b1, 2'd3, 2'd3, 3'b000};
      vecs[8] = '{4'd9, 1'b0, 2'd0, 2'd0, 3'b011};
      vecs[9] = '{4'd2, 1'b0, 2'd0, 2'd0, 3'b011};

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_set    = '0;
      req_hit    = 1'b0;
      req_way    = '0;
      resp_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset resp_valid", resp_valid, 0);
      check("reset req_ready", req_ready, 1);
      check("reset csb0", lru_csb0, 1);
      check("reset web0", lru_web0, 1);
      check("reset csb1", lru_csb1, 1);
      check("reset web1", lru_web1, 1);

      // Back-to-back table: response of vector i-1 is checked while vector i is presented.
      for (int i = 0; i <= NV; i++) begin
         @(negedge clk);
         if (i > 0) begin
            check($sformatf("v%0d resp_valid", i-1), resp_valid, 1);
            check($sformatf("v%0d resp_way", i-1), resp_way, vecs[i-1].exp_way);
            check($sformatf("v%0d csb1", i-1), lru_csb1, 0);
            check($sformatf("v%0d web1", i-1), lru_web1, 0);
            check($sformatf("v%0d addr1", i-1), lru_addr1, vecs[i-1].set);
            check($sformatf("v%0d din1", i-1), lru_din1, vecs[i-1].exp_din);
         end
         if (i < NV) begin
            req_valid = 1'b1;
            req_set   = vecs[i].set;
            req_hit   = vecs[i].hit;
            req_way   = vecs[i].way;
            #1;
            check($sformatf("v%0d req_ready", i), req_ready, 1);
            check($sformatf("v%0d csb0", i), lru_csb0, 0);
            check($sformatf("v%0d addr0", i), lru_addr0, vecs[i].set);
         end else begin
            req_valid = 1'b0;
         end
      end
      repeat (2) @(negedge clk);
      check("idle resp_valid", resp_valid, 0);
      check("idle csb1", lru_csb1, 1);
      check("array set5", mem[5], 3'b000);
      check("array set1", mem[1], 3'b111);
      check("array set2", mem[2], 3'b011);
      check("array set9", mem[9], 3'b011);

      // Stall: miss on set 7 held for 3 cycles, a second request waits behind it.
      w7_before  = wr7_count;
      req_valid  = 1'b1;
      req_set    = 4'd7;
      req_hit    = 1'b0;
      resp_ready = 1'b0;
      @(negedge clk);
      req_set = 4'd4;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("stall%0d resp_valid", c), resp_valid, 1);
         check($sformatf("stall%0d resp_way", c), resp_way, 0);
         check($sformatf("stall%0d req_ready", c), req_ready, 0);
         check($sformatf("stall%0d csb1", c), lru_csb1, 1);
         check($sformatf("stall%0d csb0", c), lru_csb0, 1);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      #1;
      check("release csb1", lru_csb1, 0);
      check("release addr1", lru_addr1, 7);
      check("release din1", lru_din1, 3'b011);
      check("release csb0", lru_csb0, 0);
      check("release addr0", lru_addr0, 4);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("after stall resp_way", resp_way, 0);
      check("after stall addr1", lru_addr1, 4);
      check("after stall din1", lru_din1, 3'b011);
      check("set7 single write", wr7_count - w7_before, 1);

      // Reset while S1 holds a stalled miss on set 7 (bits 011 -> victim way 2).
      @(negedge clk);
      req_valid  = 1'b1;
      req_set    = 4'd7;
      req_hit    = 1'b0;
      resp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("prereset resp_way", resp_way, 2);
      w_before = wr_count;
      @(negedge clk);
      rst        = 1'b1;
      resp_ready = 1'b1;
      #1;
      check("in reset csb1", lru_csb1, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post reset resp_valid", resp_valid, 0);
      check("post reset req_ready", req_ready, 1);
      check("no write across reset", wr_count - w_before, 0);
      req_valid = 1'b1;
      req_set   = 4'd7;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("post reset resp_way", resp_way, 0);
      check("post reset din1", lru_din1, 3'b011);
      check("post reset csb1", lru_csb1, 0);
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
